// File: rtl/trng_word_reader.sv
// Samples an asynchronous TRNG bit stream, XOR-folds it by DECIM, runs a repetition-count
// health test on the folded bits and hands out WORD_W-bit words over a valid/ready handshake.
module trng_word_reader #(
  parameter int WORD_W    = 32,
  parameter int DECIM     = 1,
  parameter int RCT_LIMIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bit,
  input  logic              i_ready,
  input  logic              i_clr_fail,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_fail,
  output logic              o_ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam int              BCW     = $clog2(WORD_W + 1);
  localparam logic [4:0]      DECIM_C = 5'(DECIM);
  localparam logic [BCW-1:0]  WORD_C  = BCW'(WORD_W);
  localparam logic [5:0]      RCT_C   = 6'(RCT_LIMIT);

  logic              sync1_q, sync2_q;
  logic [1:0]        state_q, state_d;
  logic              acc_q, acc_d;
  logic [4:0]        dec_q, dec_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [5:0]        rep_q, rep_d;
  logic              prev_q, prev_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fail_q, fail_d;
  logic              ovf_q, ovf_d;

  logic              fold_bit;
  logic [4:0]        dec_nxt;
  logic [BCW-1:0]    bit_nxt;
  logic [WORD_W-1:0] shift_nxt;
  logic [5:0]        rep_nxt;
  logic              xfer;
  logic              clr_cnt;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dec_d     = dec_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rep_d     = rep_q;
    prev_d    = prev_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fail_d    = fail_q;
    ovf_d     = ovf_q;
    clr_cnt   = 1'b0;

    fold_bit  = acc_q ^ sync2_q;
    dec_nxt   = dec_q + 5'd1;
    bit_nxt   = bit_cnt_q + BCW'(1);
    shift_nxt = {shift_q[WORD_W-2:0], fold_bit};
    // rep_q == 0 marks "no folded bit seen since entering FILL"
    rep_nxt   = (rep_q == 6'd0 || fold_bit != prev_q) ? 6'd1 : rep_q + 6'd1;
    xfer      = valid_q & i_ready & (state_q != ST_FAIL);

    if (i_clr_fail) ovf_d = 1'b0;
    if (xfer) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end else if (dec_nxt == DECIM_C) begin
          acc_d     = 1'b0;
          dec_d     = 5'd0;
          prev_d    = fold_bit;
          rep_d     = rep_nxt;
          shift_d   = shift_nxt;
          bit_cnt_d = bit_nxt;
          if (rep_nxt == RCT_C) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            valid_d = 1'b0;
            clr_cnt = 1'b1;
          end else if (bit_nxt == WORD_C) begin
            bit_cnt_d = '0;
            if (!valid_q || xfer) begin
              data_d  = shift_nxt;
              valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          acc_d = fold_bit;
          dec_d = dec_nxt;
        end
      end
      ST_FAIL: begin
        if (i_clr_fail) begin
          fail_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = i_en ? ST_FILL : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clr_cnt = 1'b1;
      end
    endcase

    // Counters stay zero outside FILL so every entry into FILL starts clean
    if (clr_cnt) begin
      acc_d     = 1'b0;
      dec_d     = 5'd0;
      bit_cnt_d = '0;
      shift_d   = '0;
      rep_d     = 6'd0;
      prev_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      acc_q     <= 1'b0;
      dec_q     <= 5'd0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rep_q     <= 6'd0;
      prev_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= i_bit;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      acc_q     <= acc_d;
      dec_q     <= dec_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rep_q     <= rep_d;
      prev_q    <= prev_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_fail  = fail_q;
  assign o_ovf   = ovf_q;

endmodule
